// File: rtl/sync_measure.sv
// sync_measure: measures normalized hsync/vsync timing and declares lock once stable.
// Optional INTERLACE_SYNC_EN: +/-1 line fields also match; interlaced flag reported.
module sync_measure #(
  parameter int unsigned CW            = 12,
  parameter int unsigned LW            = 10,
  parameter int unsigned STABLE_FRAMES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hs_in,
  input  logic          vs_in,
  output logic [CW-1:0] h_period,
  output logic [CW-1:0] h_width,
  output logic [LW-1:0] v_lines,
  output logic [LW-1:0] v_width,
  output logic          locked,
  output logic          mode_change,
  output logic          interlaced
);
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW-1:0] HMAX = '1;
  localparam logic [LW-1:0] LMAX = '1;
  localparam logic [4:0] LOCK_CNT = 5'(STABLE_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
  state_t state, state_nxt;

  logic hs_s1, hs_s2, hs_d, vs_s1, vs_s2, vs_d;
  logic hs_rise, hs_fall, vs_rise, vs_fall;
  logic [CW-1:0] hcnt, cur_hp, cur_hw, ref_hp, ref_hw;
  logic [LW-1:0] lcnt, cur_vw, lines_c, ref_vl, ref_vw;
  logic [3:0]    match_cnt;
  logic          miss;
  logic          hp_ok_c, hw_ok_c, vl_ok_c, match_c, timeout_c;
  logic          store_ref, cnt_clr, cnt_inc, miss_set, miss_clr, go_lock, go_unlock;

  function automatic logic near1(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] ae, be;
    ae = {1'b0, a};
    be = {1'b0, b};
    return (ae == be) || (ae == be + CW1'(1)) || (be == ae + CW1'(1));
  endfunction

  // 2-FF synchronizers plus edge-detect stage
  always_ff @(posedge clk) begin
    if (reset) begin
      {hs_s1, hs_s2, hs_d} <= 3'b000;
      {vs_s1, vs_s2, vs_d} <= 3'b000;
    end else begin
      {hs_s1, hs_s2, hs_d} <= {hs_in, hs_s1, hs_s2};
      {vs_s1, vs_s2, vs_d} <= {vs_in, vs_s1, vs_s2};
    end
  end

  assign hs_rise = hs_s2 & ~hs_d;
  assign hs_fall = ~hs_s2 & hs_d;
  assign vs_rise = vs_s2 & ~vs_d;
  assign vs_fall = ~vs_s2 & vs_d;

  // Line count including an hs rise on this very clk
  assign lines_c = (hs_rise && (lcnt != LMAX)) ? lcnt + LW'(1) : lcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt   <= '0;
      lcnt   <= '0;
      cur_hp <= '0;
      cur_hw <= '0;
      cur_vw <= '0;
    end else begin
      if (hs_rise) begin
        cur_hp <= hcnt;
        hcnt   <= CW'(1);
      end else if (hcnt != HMAX) begin
        hcnt <= hcnt + CW'(1);
      end
      if (hs_fall) cur_hw <= hcnt;
      lcnt <= vs_rise ? '0 : lines_c;
      if (vs_fall) cur_vw <= lines_c;
    end
  end

  assign hp_ok_c = near1(cur_hp, ref_hp);
  assign hw_ok_c = near1(cur_hw, ref_hw);
`ifdef INTERLACE_SYNC_EN
  localparam int unsigned LW1 = LW + 1;
  logic vl_step_c;
  assign vl_step_c = ({1'b0, lines_c} == {1'b0, ref_vl} + LW1'(1)) ||
                     ({1'b0, ref_vl} == {1'b0, lines_c} + LW1'(1));
  assign vl_ok_c   = (lines_c == ref_vl) || vl_step_c;
`else
  assign vl_ok_c   = (lines_c == ref_vl);
`endif
  assign match_c   = hp_ok_c && hw_ok_c && vl_ok_c && (cur_vw == ref_vw);
  assign timeout_c = (hcnt == HMAX) || (lcnt == LMAX);

  always_ff @(posedge clk) begin
    if (reset) state <= SEARCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    store_ref = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    miss_set  = 1'b0;
    miss_clr  = 1'b0;
    go_lock   = 1'b0;
    go_unlock = 1'b0;
    if (timeout_c) begin
      state_nxt = SEARCH;
      go_unlock = 1'b1;
      cnt_clr   = 1'b1;
      miss_clr  = 1'b1;
    end else if (vs_rise) begin
      // Reference always tracks the previous frame's candidate
      store_ref = 1'b1;
      case (state)
        SEARCH: begin
          cnt_clr   = 1'b1;
          state_nxt = CHECK;
        end
        CHECK: begin
          if (!match_c) begin
            cnt_clr = 1'b1;
          end else if (5'(match_cnt) + 5'd1 >= LOCK_CNT) begin
            state_nxt = LOCKED;
            go_lock   = 1'b1;
            miss_clr  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        LOCKED: begin
          if (match_c) begin
            miss_clr = 1'b1;
          end else if (miss) begin
            state_nxt = SEARCH;
            go_unlock = 1'b1;
            miss_clr  = 1'b1;
            cnt_clr   = 1'b1;
          end else begin
            miss_set = 1'b1;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_hp      <= '0;
      ref_hw      <= '0;
      ref_vl      <= '0;
      ref_vw      <= '0;
      match_cnt   <= '0;
      miss        <= 1'b0;
      h_period    <= '0;
      h_width     <= '0;
      v_lines     <= '0;
      v_width     <= '0;
      locked      <= 1'b0;
      mode_change <= 1'b0;
    end else begin
      mode_change <= go_lock;
      if (store_ref) begin
        ref_hp <= cur_hp;
        ref_hw <= cur_hw;
        ref_vl <= lines_c;
        ref_vw <= cur_vw;
      end
      if (cnt_clr)      match_cnt <= '0;
      else if (cnt_inc) match_cnt <= match_cnt + 4'd1;
      if (miss_clr)      miss <= 1'b0;
      else if (miss_set) miss <= 1'b1;
      if (go_lock) begin
        locked   <= 1'b1;
        h_period <= cur_hp;
        h_width  <= cur_hw;
        v_width  <= cur_vw;
`ifdef INTERLACE_SYNC_EN
        v_lines  <= (lines_c < ref_vl) ? lines_c : ref_vl;
`else
        v_lines  <= lines_c;
`endif
      end else if (go_unlock) begin
        locked <= 1'b0;
      end
    end
  end

`ifdef INTERLACE_SYNC_EN
  always_ff @(posedge clk) begin
    if (reset || go_unlock)                          interlaced <= 1'b0;
    else if (vs_rise && (go_lock || state == LOCKED)) interlaced <= vl_step_c;
  end
`else
  assign interlaced = 1'b0;
`endif

endmodule

// File: tb/tb_sync_measure.sv
// tb_sync_measure: table-driven, hand-sequenced and randomized checks of sync_measure
// against a frame-history reference model.
module tb_sync_measure;
  localparam int unsigned CW = 12;
  localparam int unsigned LW = 10;
  localparam int SF = 4;

  typedef struct { int hp; int hw; int vl; int vw; } frm_t;
  typedef struct { frm_t stim; int exp_hp; int exp_hw; int exp_vl; int exp_vw; } vec_t;

  logic clk = 1'b0;
  logic reset, hs_in, vs_in;
  logic [CW-1:0] h_period, h_width;
  logic [LW-1:0] v_lines, v_width;
  logic locked, mode_change, interlaced;

  sync_measure dut (
    .clk(clk), .reset(reset), .hs_in(hs_in), .vs_in(vs_in),
    .h_period(h_period), .h_width(h_width), .v_lines(v_lines), .v_width(v_width),
    .locked(locked), .mode_change(mode_change), .interlaced(interlaced)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int mc_seen = 0;

  always @(posedge clk) if (mode_change === 1'b1) mc_seen++;

  // Reference model state: history of frame matches since the last restart
  bit   m_locked, m_search, m_inter, pc_valid;
  frm_t pc, gen_prev;
  int   gen_cnt, mc_exp;
  int   m_hp, m_hw, m_vl, m_vw;
  bit   mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  function automatic bit near(input int a, input int b);
    return (a - b <= 1) && (b - a <= 1);
  endfunction

  function automatic bit fmatch(input frm_t a, input frm_t b);
    bit vok;
    vok = (a.vl == b.vl);
`ifdef INTERLACE_SYNC_EN
    vok = near(a.vl, b.vl);
`endif
    return near(a.hp, b.hp) && near(a.hw, b.hw) && vok && (a.vw == b.vw);
  endfunction

  function automatic bit vstep(input int a, input int b);
`ifdef INTERLACE_SYNC_EN
    return (a - b == 1) || (b - a == 1);
`else
    return (a != a);
`endif
  endfunction

  task automatic model_reset();
    m_locked = 0; m_search = 1; m_inter = 0; pc_valid = 0; gen_cnt = 0;
    m_hp = 0; m_hw = 0; m_vl = 0; m_vw = 0;
    mq.delete();
  endtask

  // At a vs rise the DUT sees: last line period and vsync of the previous frame, hs width of this one
  task automatic model_frame(input frm_t f);
    frm_t c;
    bit cv, m;
    int t;
    c.hp = gen_prev.hp; c.hw = f.hw; c.vl = gen_prev.vl; c.vw = gen_prev.vw;
    cv = (gen_cnt > 0);
    if (m_search) begin
      m_search = 0;
      mq.delete();
    end else begin
      m = pc_valid && cv && fmatch(c, pc);
      mq.push_back(m);
      if (!m_locked) begin
        t = 0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
          if (!mq[i]) break;
          t++;
        end
        if (t >= SF - 1) begin
          m_locked = 1; mc_exp++;
          m_hp = c.hp; m_hw = c.hw; m_vl = c.vl; m_vw = c.vw;
          if (vstep(c.vl, pc.vl) && pc.vl < c.vl) m_vl = pc.vl;
          m_inter = vstep(c.vl, pc.vl);
          mq.delete();
        end
      end else if (mq.size() >= 2 && !mq[mq.size()-1] && !mq[mq.size()-2]) begin
        m_locked = 0; m_search = 1; m_inter = 0;
      end else begin
        m_inter = vstep(c.vl, pc.vl);
      end
    end
    pc = c; pc_valid = cv; gen_prev = f; gen_cnt++;
  endtask

  task automatic send(input frm_t f);
    for (int l = 0; l < f.vl; l++) begin
      for (int k = 0; k < f.hp; k++) begin
        hs_in = (k < f.hw);
        if (k == f.hw + 2) begin
          if (l == 0) vs_in = 1'b1;
          else if (l == f.vw) vs_in = 1'b0;
        end
        @(negedge clk);
      end
    end
    model_frame(f);
  endtask

  task automatic do_reset();
    hs_in = 1'b0; vs_in = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".locked"},     32'(locked),     32'(m_locked));
    chk({tag, ".h_period"},   32'(h_period),   m_hp);
    chk({tag, ".h_width"},    32'(h_width),    m_hw);
    chk({tag, ".v_lines"},    32'(v_lines),    m_vl);
    chk({tag, ".v_width"},    32'(v_width),    m_vw);
    chk({tag, ".interlaced"}, 32'(interlaced), 32'(m_inter));
    chk({tag, ".mode_cnt"},   mc_seen,         mc_exp);
  endtask

  initial begin
    vec_t tbl[5];
    frm_t fa, fb, f;
    int mc0, waited, jit[5], mode;

    fa = '{32, 5, 12, 2};
    fb = '{40, 8, 15, 3};
    mc_exp = 0;
    tbl[0] = '{'{32, 5, 12, 2}, 32, 5, 12, 2};
    tbl[1] = '{'{40, 6, 16, 3}, 40, 6, 16, 3};
    tbl[2] = '{'{50, 10, 20, 5}, 50, 10, 20, 5};
    tbl[3] = '{'{36, 30, 14, 4}, 36, 30, 14, 4};
    tbl[4] = '{'{24, 3, 4, 1}, 24, 3, 4, 1};

    do_reset();
    chk("rst.locked", 32'(locked), 0);
    chk("rst.h_period", 32'(h_period), 0);
    chk("rst.v_lines", 32'(v_lines), 0);
    chk("rst.mode_change", 32'(mode_change), 0);

    // Steady modes: lock on exactly the 5th vs rise with one mode_change pulse
    for (int i = 0; i < 5; i++) begin
      do_reset();
      for (int n = 0; n < 4; n++) send(tbl[i].stim);
      chk("tbl.prelock", 32'(locked), 0);
      mc0 = mc_seen;
      send(tbl[i].stim);
      chk("tbl.locked", 32'(locked), 1);
      chk("tbl.h_period", 32'(h_period), tbl[i].exp_hp);
      chk("tbl.h_width", 32'(h_width), tbl[i].exp_hw);
      chk("tbl.v_lines", 32'(v_lines), tbl[i].exp_vl);
      chk("tbl.v_width", 32'(v_width), tbl[i].exp_vw);
      send(tbl[i].stim);
      chk("tbl.one_pulse", mc_seen - mc0, 1);
      check_model("tbl");
    end

    // Period jitter of one clock stays locked
    do_reset();
    repeat (5) send(fa);
    mc0 = mc_seen;
    jit = '{31, 32, 33, 32, 31};
    for (int i = 0; i < 5; i++) begin
      f = fa; f.hp = jit[i];
      send(f);
      chk("jit.locked", 32'(locked), 1);
      check_model("jit");
    end
    chk("jit.h_period", 32'(h_period), 32);
    chk("jit.no_pulse", mc_seen - mc0, 0);

    // Mode switch: one miss tolerated, second drops lock, relock after 4 more frames
    do_reset();
    repeat (5) send(fa);
    send(fb); chk("sw.miss1", 32'(locked), 1);
    send(fb); chk("sw.miss2", 32'(locked), 0);
    for (int n = 0; n < 3; n++) begin
      send(fb); chk("sw.search", 32'(locked), 0);
    end
    send(fb);
    chk("sw.relock", 32'(locked), 1);
    chk("sw.h_period", 32'(h_period), 40);
    chk("sw.v_lines", 32'(v_lines), 15);
    check_model("sw");

    // hs stops: lock drops by hcnt saturation, outputs hold
    do_reset();
    repeat (5) send(fa);
    hs_in = 1'b0;
    repeat (3000) @(negedge clk);
    chk("to.early", 32'(locked), 1);
    waited = 0;
    while (locked === 1'b1 && waited < 1200) begin
      @(negedge clk);
      waited++;
    end
    chk("to.dropped", 32'(locked), 0);
    chk("to.h_period", 32'(h_period), 32);
    chk("to.h_width", 32'(h_width), 5);
    chk("to.v_lines", 32'(v_lines), 12);
    chk("to.v_width", 32'(v_width), 2);

    // Alternating 12/13-line fields
    do_reset();
    for (int n = 0; n < 8; n++) begin
      f = fa; f.vl = (n % 2 == 1) ? 13 : 12;
      send(f);
      check_model("il");
    end
`ifdef INTERLACE_SYNC_EN
    chk("il.locked", 32'(locked), 1);
    chk("il.interlaced", 32'(interlaced), 1);
    chk("il.v_lines", 32'(v_lines), 12);
`else
    chk("il.locked", 32'(locked), 0);
    chk("il.interlaced", 32'(interlaced), 0);
`endif

    // One-clock reset while locked
    do_reset();
    repeat (5) send(fa);
    chk("rm.locked", 32'(locked), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("rm.locked0", 32'(locked), 0);
    chk("rm.h_period0", 32'(h_period), 0);
    chk("rm.h_width0", 32'(h_width), 0);
    chk("rm.v_lines0", 32'(v_lines), 0);
    chk("rm.v_width0", 32'(v_width), 0);
    repeat (4) send(fa);
    chk("rm.prelock", 32'(locked), 0);
    send(fa);
    chk("rm.relock", 32'(locked), 1);
    check_model("rm");

    // Random mode hopping with occasional jitter
    do_reset();
    mode = 0;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 9) < 2) mode = 1 - mode;
      f = (mode == 0) ? fa : fb;
      if ($urandom_range(0, 3) == 0) f.hp = f.hp + int'($urandom_range(0, 2)) - 1;
      send(f);
      check_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
